// File: rtl/cancela_atuador.sv
// Gate/lamp actuator for the level-crossing controller: drives the gate motor with
// limit, timeout and reversal dead-time handling plus the flashing lamps.
// Optional build macro SEMAFORO_INTERLOCK_EN forces alternating lamps while the gate is not up.
module cancela_atuador #(
  parameter int unsigned T_CURSO = 1000,
  parameter int unsigned T_PAUSA = 4,
  parameter int unsigned T_PISCA = 50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] cmd_cancela,
  input  logic [1:0] cmd_semaforo,
  input  logic       fim_baixo,
  input  logic       fim_alto,
  output logic       motor_desce,
  output logic       motor_sobe,
  output logic       lamp_a,
  output logic       lamp_b,
  output logic [1:0] pos,
  output logic       falha
);

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] CMD_FECHA = 2'b01;
  localparam logic [1:0] CMD_ABRE  = 2'b10;

  localparam logic [1:0] SRC_OFF = 2'b00;
  localparam logic [1:0] SRC_A   = 2'b01;
  localparam logic [1:0] SRC_B   = 2'b10;
  localparam logic [1:0] SRC_ALT = 2'b11;

  localparam logic [1:0] POS_MOV   = 2'b00;
  localparam logic [1:0] POS_BAIXO = 2'b01;
  localparam logic [1:0] POS_ALTO  = 2'b10;
  localparam logic [1:0] POS_FALHA = 2'b11;

  localparam logic [CNT_W-1:0] CURSO_FIM = CNT_W'(T_CURSO - 1);
  localparam logic [CNT_W-1:0] PAUSA_FIM = CNT_W'(T_PAUSA - 1);
  localparam logic [CNT_W-1:0] PISCA_FIM = CNT_W'(T_PISCA - 1);

  typedef enum logic [2:0] {
    INICIO   = 3'd0,
    ALTO     = 3'd1,
    DESCENDO = 3'd2,
    BAIXO    = 3'd3,
    SUBINDO  = 3'd4,
    PAUSA    = 3'd5,
    FALHA    = 3'd6
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pend_sobe, pend_sobe_nxt;
  logic [1:0]       src, src_nxt;
  logic [CNT_W-1:0] pisca_cnt, pisca_cnt_nxt;
  logic             fase, fase_nxt;
  logic             fecha, abre;

  logic             motor_desce_nxt, motor_sobe_nxt, falha_nxt;
  logic             lamp_a_nxt, lamp_b_nxt;
  logic [1:0]       pos_nxt;

  assign fecha = (cmd_cancela == CMD_FECHA);
  assign abre  = (cmd_cancela == CMD_ABRE);

  // State, shared motion/pause timer, pending direction and flasher registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INICIO;
      cnt       <= '0;
      pend_sobe <= 1'b0;
      src       <= SRC_OFF;
      pisca_cnt <= '0;
      fase      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pend_sobe <= pend_sobe_nxt;
      src       <= src_nxt;
      pisca_cnt <= pisca_cnt_nxt;
      fase      <= fase_nxt;
    end
  end

  // Next state; the timer restarts on every state change and only advances while staying
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = '0;
    pend_sobe_nxt = pend_sobe;
    if (fim_baixo && fim_alto) begin
      state_nxt = FALHA;
    end else begin
      case (state)
        INICIO: begin
          if (fim_alto)       state_nxt = ALTO;
          else if (fim_baixo) state_nxt = BAIXO;
          else if (fecha)     state_nxt = DESCENDO;
          else if (abre)      state_nxt = SUBINDO;
        end
        ALTO:  if (fecha) state_nxt = DESCENDO;
        BAIXO: if (abre)  state_nxt = SUBINDO;
        DESCENDO: begin
          if (fim_baixo)              state_nxt = BAIXO;
          else if (cnt == CURSO_FIM)  state_nxt = FALHA;
          else if (abre) begin
            state_nxt     = PAUSA;
            pend_sobe_nxt = 1'b1;
          end else                    cnt_nxt = cnt + CNT_W'(1);
        end
        SUBINDO: begin
          if (fim_alto)               state_nxt = ALTO;
          else if (cnt == CURSO_FIM)  state_nxt = FALHA;
          else if (fecha) begin
            state_nxt     = PAUSA;
            pend_sobe_nxt = 1'b0;
          end else                    cnt_nxt = cnt + CNT_W'(1);
        end
        PAUSA: begin
          if (cnt == PAUSA_FIM) state_nxt = pend_sobe ? SUBINDO : DESCENDO;
          else                  cnt_nxt = cnt + CNT_W'(1);
        end
        FALHA:   state_nxt = FALHA;
        default: state_nxt = INICIO;
      endcase
    end
  end

  // Lamp source selection and flasher; any source change restarts at phase on
  always_comb begin
    src_nxt       = SRC_OFF;
    pisca_cnt_nxt = '0;
    fase_nxt      = 1'b1;
    if (state_nxt == FALHA) begin
      src_nxt = SRC_ALT;
`ifdef SEMAFORO_INTERLOCK_EN
    end else if (state_nxt inside {DESCENDO, PAUSA, BAIXO, SUBINDO}) begin
      src_nxt = SRC_ALT;
`endif
    end else if (cmd_semaforo != SRC_ALT) begin
      src_nxt = cmd_semaforo;
    end
    if (src_nxt == src && src_nxt != SRC_OFF) begin
      if (pisca_cnt == PISCA_FIM) begin
        fase_nxt = ~fase;
      end else begin
        pisca_cnt_nxt = pisca_cnt + CNT_W'(1);
        fase_nxt      = fase;
      end
    end
  end

  // Moore output decode of the upcoming state
  always_comb begin
    motor_desce_nxt = (state_nxt == DESCENDO);
    motor_sobe_nxt  = (state_nxt == SUBINDO);
    falha_nxt       = (state_nxt == FALHA);
    case (state_nxt)
      ALTO:    pos_nxt = POS_ALTO;
      BAIXO:   pos_nxt = POS_BAIXO;
      FALHA:   pos_nxt = POS_FALHA;
      default: pos_nxt = POS_MOV;
    endcase
    lamp_a_nxt = ((src_nxt == SRC_A) || (src_nxt == SRC_ALT)) && fase_nxt;
    lamp_b_nxt = ((src_nxt == SRC_B) && fase_nxt) || ((src_nxt == SRC_ALT) && !fase_nxt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      motor_desce <= 1'b0;
      motor_sobe  <= 1'b0;
      lamp_a      <= 1'b0;
      lamp_b      <= 1'b0;
      pos         <= POS_MOV;
      falha       <= 1'b0;
    end else begin
      motor_desce <= motor_desce_nxt;
      motor_sobe  <= motor_sobe_nxt;
      lamp_a      <= lamp_a_nxt;
      lamp_b      <= lamp_b_nxt;
      pos         <= pos_nxt;
      falha       <= falha_nxt;
    end
  end

endmodule

// File: tb/tb_cancela_atuador.sv
// Directed self-checking bench for cancela_atuador (T_CURSO=20, T_PAUSA=2, T_PISCA=3).
// Build with SEMAFORO_INTERLOCK_EN defined to also cover the lamp interlock.
module tb_cancela_atuador;

  logic       clk;
  logic       reset_n;
  logic [1:0] cmd_cancela;
  logic [1:0] cmd_semaforo;
  logic       fim_baixo;
  logic       fim_alto;
  logic       motor_desce;
  logic       motor_sobe;
  logic       lamp_a;
  logic       lamp_b;
  logic [1:0] pos;
  logic       falha;

  int n_vec = 0;
  int n_err = 0;

  // {motor_desce, motor_sobe, pos, falha}
  localparam logic [4:0] G_INI   = 5'b00000;
  localparam logic [4:0] G_ALTO  = 5'b00100;
  localparam logic [4:0] G_DESC  = 5'b10000;
  localparam logic [4:0] G_BAIXO = 5'b00010;
  localparam logic [4:0] G_SOBE  = 5'b01000;
  localparam logic [4:0] G_PAUSA = 5'b00000;
  localparam logic [4:0] G_FALHA = 5'b00111;

  cancela_atuador #(
    .T_CURSO(20),
    .T_PAUSA(2),
    .T_PISCA(3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_cancela (cmd_cancela),
    .cmd_semaforo(cmd_semaforo),
    .fim_baixo   (fim_baixo),
    .fim_alto    (fim_alto),
    .motor_desce (motor_desce),
    .motor_sobe  (motor_sobe),
    .lamp_a      (lamp_a),
    .lamp_b      (lamp_b),
    .pos         (pos),
    .falha       (falha)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [4:0] gate();
    return {motor_desce, motor_sobe, pos, falha};
  endfunction

  logic [11:0] pat;

  initial begin
    reset_n      = 1'b0;
    cmd_cancela  = 2'b00;
    cmd_semaforo = 2'b00;
    fim_baixo    = 1'b0;
    fim_alto     = 1'b1;
    pat          = 12'b111000111000;

    tick(2);
    check("reset_outs", 32'({gate(), lamp_a, lamp_b}), 32'd0);

    // Scenario 1: power-up at top, close, reach lower limit
    reset_n = 1'b1;
    tick(1);
    check("init_to_alto", 32'(gate()), 32'(G_ALTO));
    cmd_cancela = 2'b01;
    fim_alto    = 1'b0;
    tick(1);
    check("close_start", 32'(gate()), 32'(G_DESC));
    tick(4);
    check("closing_5cyc", 32'(gate()), 32'(G_DESC));
    fim_baixo = 1'b1;
    tick(1);
    check("reach_baixo", 32'(gate()), 32'(G_BAIXO));
    cmd_cancela = 2'b00;
    tick(2);
    check("hold_baixo", 32'(gate()), 32'(G_BAIXO));

    // Scenario 2: reversals through the dead-time in both directions
    cmd_cancela = 2'b10;
    fim_baixo   = 1'b0;
    tick(1);
    check("open_start", 32'(gate()), 32'(G_SOBE));
    check("excl_a", 32'(motor_desce & motor_sobe), 32'd0);
    tick(1);
    check("opening", 32'(gate()), 32'(G_SOBE));
    cmd_cancela = 2'b01;
    tick(1);
    check("pausa_dn_1", 32'(gate()), 32'(G_PAUSA));
    tick(1);
    check("pausa_dn_2", 32'(gate()), 32'(G_PAUSA));
    tick(1);
    check("rev_to_desc", 32'(gate()), 32'(G_DESC));
    cmd_cancela = 2'b10;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      check("pausa_up", 32'(gate()), 32'(G_PAUSA));
      check("excl_b", 32'(motor_desce & motor_sobe), 32'd0);
    end
    tick(1);
    check("rev_to_sobe", 32'(gate()), 32'(G_SOBE));
    cmd_cancela = 2'b00;
    fim_alto    = 1'b1;
    tick(1);
    check("reach_alto", 32'(gate()), 32'(G_ALTO));
    check("alto_lamps_off", 32'({lamp_a, lamp_b}), 32'd0);

    // Scenario 5: lamp flashing and restart on source change
    cmd_semaforo = 2'b01;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check($sformatf("lampa_%0d", i), 32'({lamp_a, lamp_b}), 32'({pat[11-i], 1'b0}));
    end
    cmd_semaforo = 2'b10;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check($sformatf("lampb_%0d", i), 32'({lamp_a, lamp_b}), 32'({1'b0, pat[11-i]}));
    end
    cmd_semaforo = 2'b11;
    tick(1);
    check("sem11_off", 32'({lamp_a, lamp_b}), 32'd0);
    cmd_semaforo = 2'b00;
    cmd_cancela  = 2'b11;
    tick(2);
    check("cmd11_alto", 32'(gate()), 32'(G_ALTO));

    // Scenario 3: travel timeout into sticky fault
    cmd_cancela = 2'b01;
    fim_alto    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check($sformatf("travel_%0d", i), 32'(gate()), 32'(G_DESC));
    end
    tick(1);
    check("timeout_falha", 32'(gate()), 32'(G_FALHA));
    check("falha_alt", 32'(lamp_a ^ lamp_b), 32'd1);
`ifndef SEMAFORO_INTERLOCK_EN
    check("falha_lamp_ph0", 32'({lamp_a, lamp_b}), 32'b10);
`endif
    cmd_cancela = 2'b10;
    tick(3);
    check("falha_sticky", 32'(gate()), 32'(G_FALHA));
`ifndef SEMAFORO_INTERLOCK_EN
    check("falha_lamp_ph1", 32'({lamp_a, lamp_b}), 32'b01);
`endif
    reset_n = 1'b0;
    #1;
    check("async_reset", 32'({gate(), lamp_a, lamp_b}), 32'd0);
    cmd_cancela = 2'b11;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check("cmd11_inicio", 32'(gate()), 32'(G_INI));

    // Limit reached beats a simultaneous reverse command
    cmd_cancela = 2'b01;
    tick(1);
    check("inicio_close", 32'(gate()), 32'(G_DESC));
    cmd_cancela = 2'b10;
    fim_baixo   = 1'b1;
    tick(1);
    check("limit_wins", 32'(gate()), 32'(G_BAIXO));

    // Scenario 4: both limit switches at once
    cmd_cancela = 2'b00;
    fim_alto    = 1'b1;
    tick(1);
    check("both_limits", 32'(gate()), 32'(G_FALHA));

    reset_n = 1'b0;
    tick(1);
    fim_baixo = 1'b0;
    reset_n   = 1'b1;
    tick(1);
    check("reinit_alto", 32'(gate()), 32'(G_ALTO));

`ifdef SEMAFORO_INTERLOCK_EN
    // Scenario 6: lamps alternate from leaving the top until the top is reached again
    check("il_alto_off", 32'({lamp_a, lamp_b}), 32'd0);
    cmd_cancela = 2'b01;
    fim_alto    = 1'b0;
    tick(1);
    check("il_desc", 32'({lamp_a, lamp_b}), 32'b10);
    fim_baixo = 1'b1;
    tick(1);
    check("il_baixo_gate", 32'(gate()), 32'(G_BAIXO));
    check("il_baixo", 32'(lamp_a ^ lamp_b), 32'd1);
    cmd_cancela = 2'b10;
    fim_baixo   = 1'b0;
    tick(1);
    check("il_sobe", 32'(lamp_a ^ lamp_b), 32'd1);
    cmd_cancela = 2'b00;
    fim_alto    = 1'b1;
    tick(1);
    check("il_alto_gate", 32'(gate()), 32'(G_ALTO));
    check("il_alto_end", 32'({lamp_a, lamp_b}), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
